// File: rtl/voice_allocator.sv
// voice_allocator: shadow voice table that turns note events into single
// port-A write commands (retrigger, free slot, or steal the oldest voice).
`timescale 1ns/1ps
module voice_allocator #(
    parameter int NUM_VOICES = 32,
    parameter int AGE_W      = 8
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_on,
    input  logic [6:0] ev_note,
    input  logic [3:0] ev_channel,
    input  logic [6:0] ev_velocity,
    input  logic [7:0] smp_addr,
    input  logic       smp_busy,
    output logic       cmd_valid,
    output logic [7:0] cmd_addr,
    output logic       cmd_on,
    output logic [6:0] cmd_note,
    output logic [3:0] cmd_channel,
    output logic [6:0] cmd_velocity,
    output logic [7:0] steal_count,
    output logic [7:0] drop_count
);
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {FREE = 2'd0, HELD = 2'd1, RELEASED = 2'd2} slot_t;
    typedef enum logic [2:0] {IDLE, SCAN, DECIDE, HOLD, ISSUE, DROP} state_t;

    state_t           state;
    slot_t            sl_st   [NUM_VOICES];
    logic [6:0]       sl_note [NUM_VOICES];
    logic [3:0]       sl_ch   [NUM_VOICES];
    logic [AGE_W-1:0] sl_age  [NUM_VOICES];

    logic [IW-1:0]    idx;
    logic             steal_q, drop_q;
    logic             has_m, has_f, has_r, has_h;
    logic [IW-1:0]    m_i, f_i, r_i, h_i;
    logic [AGE_W-1:0] r_age, h_age;

    logic             n_has_m, n_has_f, n_has_r, n_has_h;
    logic [IW-1:0]    n_m_i, n_f_i, n_r_i, n_h_i;
    logic [AGE_W-1:0] n_r_age, n_h_age;
    logic [IW-1:0]    dec_i;
    logic             dec_steal, dec_drop;
    logic             same, is_match, conflict;

    assign conflict = smp_busy && (smp_addr == cmd_addr);

    // Fold slot idx into the running candidates; strict '>' keeps lowest index on ties.
    always_comb begin
        n_has_m = has_m; n_m_i = m_i;
        n_has_f = has_f; n_f_i = f_i;
        n_has_r = has_r; n_r_i = r_i; n_r_age = r_age;
        n_has_h = has_h; n_h_i = h_i; n_h_age = h_age;
        same     = (sl_note[idx] == cmd_note) && (sl_ch[idx] == cmd_channel);
        is_match = same && (cmd_on ? (sl_st[idx] != FREE) : (sl_st[idx] == HELD));
        if (is_match && !has_m) begin
            n_has_m = 1'b1; n_m_i = idx;
        end
        if (sl_st[idx] == FREE && !has_f) begin
            n_has_f = 1'b1; n_f_i = idx;
        end
        if (sl_st[idx] == RELEASED && (!has_r || sl_age[idx] > r_age)) begin
            n_has_r = 1'b1; n_r_i = idx; n_r_age = sl_age[idx];
        end
        if (sl_st[idx] == HELD && (!has_h || sl_age[idx] > h_age)) begin
            n_has_h = 1'b1; n_h_i = idx; n_h_age = sl_age[idx];
        end
        dec_i     = n_m_i;
        dec_steal = 1'b0;
        dec_drop  = 1'b0;
        if (cmd_on) begin
            if (n_has_m)      dec_i = n_m_i;
            else if (n_has_f) dec_i = n_f_i;
            else if (n_has_r) dec_i = n_r_i;
            else begin
                dec_i     = n_h_i;
                dec_steal = 1'b1;
            end
        end else begin
            dec_drop = !n_has_m;
        end
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            state        <= IDLE;
            ev_ready     <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_addr     <= '0;
            cmd_on       <= 1'b0;
            cmd_note     <= '0;
            cmd_channel  <= '0;
            cmd_velocity <= '0;
            steal_count  <= '0;
            drop_count   <= '0;
            idx          <= '0;
            steal_q      <= 1'b0;
            drop_q       <= 1'b0;
            has_m <= 1'b0; has_f <= 1'b0; has_r <= 1'b0; has_h <= 1'b0;
            m_i <= '0; f_i <= '0; r_i <= '0; h_i <= '0;
            r_age <= '0; h_age <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                sl_st[i]   <= FREE;
                sl_note[i] <= '0;
                sl_ch[i]   <= '0;
                sl_age[i]  <= '0;
            end
        end else begin
            cmd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ev_valid && ev_ready) begin
                        ev_ready     <= 1'b0;
                        cmd_on       <= ev_on;
                        cmd_note     <= ev_note;
                        cmd_channel  <= ev_channel;
                        cmd_velocity <= ev_velocity;
                        idx          <= '0;
                        has_m <= 1'b0; has_f <= 1'b0;
                        has_r <= 1'b0; has_h <= 1'b0;
                        state        <= SCAN;
                    end else begin
                        ev_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    has_m <= n_has_m; m_i <= n_m_i;
                    has_f <= n_has_f; f_i <= n_f_i;
                    has_r <= n_has_r; r_i <= n_r_i; r_age <= n_r_age;
                    has_h <= n_has_h; h_i <= n_h_i; h_age <= n_h_age;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        cmd_addr <= 8'(dec_i);
                        steal_q  <= dec_steal;
                        drop_q   <= dec_drop;
                        state    <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (drop_q) begin
                        state <= DROP;
                    end else if (conflict) begin
                        state <= HOLD;
                    end else begin
                        cmd_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                HOLD: begin
                    if (!conflict) begin
                        cmd_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IW'(i) == cmd_addr[IW-1:0]) begin
                            if (cmd_on) begin
                                sl_st[i]   <= HELD;
                                sl_age[i]  <= '0;
                                sl_note[i] <= cmd_note;
                                sl_ch[i]   <= cmd_channel;
                            end else begin
                                sl_st[i] <= RELEASED;
                            end
                        end else if (cmd_on && sl_st[i] != FREE && sl_age[i] != AGE_MAX) begin
                            sl_age[i] <= sl_age[i] + 1'b1;
                        end
                    end
                    if (steal_q && steal_count != 8'hFF)
                        steal_count <= steal_count + 8'd1;
                    ev_ready <= 1'b1;
                    state    <= IDLE;
                end
                DROP: begin
                    if (drop_count != 8'hFF)
                        drop_count <= drop_count + 8'd1;
                    ev_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: scoreboard of expected port-A commands,
// latency / hold / drop / steal / reset checks.
`timescale 1ns/1ps
module tb_voice_allocator;
    localparam int NV  = 32;
    localparam int LAT = NV + 1;

    typedef struct {
        logic [7:0] addr;
        logic       on;
        logic [6:0] note;
        logic [3:0] ch;
        logic [6:0] vel;
    } cmd_t;

    logic       clk32 = 1'b0;
    logic       rst = 1'b1;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic       ev_on = 1'b0;
    logic [6:0] ev_note = '0;
    logic [3:0] ev_channel = '0;
    logic [6:0] ev_velocity = '0;
    logic [7:0] smp_addr = '0;
    logic       smp_busy = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic       cmd_on;
    logic [6:0] cmd_note;
    logic [3:0] cmd_channel;
    logic [6:0] cmd_velocity;
    logic [7:0] steal_count;
    logic [7:0] drop_count;

    int   n_cmp = 0;
    int   n_err = 0;
    cmd_t sb[$];

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk32(clk32), .rst(rst),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
        .ev_note(ev_note), .ev_channel(ev_channel), .ev_velocity(ev_velocity),
        .smp_addr(smp_addr), .smp_busy(smp_busy),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_on(cmd_on),
        .cmd_note(cmd_note), .cmd_channel(cmd_channel), .cmd_velocity(cmd_velocity),
        .steal_count(steal_count), .drop_count(drop_count)
    );

    always #16 clk32 = ~clk32;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cmd(input int a, input logic on, input int n, input int c, input int v);
        cmd_t e;
        e.addr = 8'(a); e.on = on; e.note = 7'(n); e.ch = 4'(c); e.vel = 7'(v);
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({ev_ready, cmd_valid, cmd_on, cmd_addr, cmd_note,
                      cmd_channel, cmd_velocity}), 32'd0);
        chk({tag, "_cnt"}, 32'({steal_count, drop_count}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; ev_valid = 1'b0; smp_busy = 1'b0;
        repeat (2) @(posedge clk32);
        #1;
        chk_zero("rst_outs");
        rst = 1'b0;
        @(posedge clk32);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ev_ready && k < 100) begin
            @(posedge clk32);
            #1;
            k++;
        end
        chk("ready_idle", 32'(ev_ready), 32'd1);
    endtask

    task automatic accept(input logic on, input int n, input int c, input int v, input int busy);
        wait_ready();
        ev_valid = 1'b1; ev_on = on; ev_note = 7'(n);
        ev_channel = 4'(c); ev_velocity = 7'(v);
        if (busy > 0) smp_busy = 1'b1;
        @(posedge clk32);
        #1;
        // Scramble the inputs: only the accepted values may reach cmd_*.
        ev_valid = 1'b0; ev_on = ~on; ev_note = 7'($urandom);
        ev_channel = 4'($urandom); ev_velocity = 7'($urandom);
        chk("ready_low", 32'(ev_ready), 32'd0);
    endtask

    // Run one event; exp_lat = edges from accept to cmd_valid sample, -1 = dropped.
    task automatic do_event(input logic on, input int n, input int c, input int v,
                            input int busy, input int exp_lat);
        int   lat, back;
        cmd_t e;
        lat = -1; back = -1;
        accept(on, n, c, v, busy);
        for (int t = 1; t <= 120 && back < 0; t++) begin
            @(posedge clk32);
            #1;
            if (t == NV + busy) smp_busy = 1'b0;
            if (cmd_valid) begin
                lat = t;
                if (sb.size() == 0) begin
                    chk("spurious_cmd", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("cmd_addr", 32'(cmd_addr), 32'(e.addr));
                    chk("cmd_on", 32'(cmd_on), 32'(e.on));
                    chk("cmd_note", 32'(cmd_note), 32'(e.note));
                    chk("cmd_ch", 32'(cmd_channel), 32'(e.ch));
                    chk("cmd_vel", 32'(cmd_velocity), 32'(e.vel));
                end
            end
            if (ev_ready) back = t;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("ready_back", 32'(back), 32'(exp_lat < 0 ? NV + 2 : exp_lat + 1));
        chk("sb_left", 32'(sb.size()), 32'd0);
        sb.delete();
        smp_busy = 1'b0;
    endtask

    initial begin
        int cnt;
        // 1: reset, first note-on lands in slot 0
        do_reset();
        expect_cmd(0, 1'b1, 60, 0, 100);
        do_event(1'b1, 60, 0, 100, 0, LAT);

        // 2: note-off releases slot 0
        expect_cmd(0, 1'b0, 60, 0, 64);
        do_event(1'b0, 60, 0, 64, 0, LAT);
        chk("drop_after_off", 32'(drop_count), 32'd0);
        expect_cmd(1, 1'b1, 62, 0, 50);
        do_event(1'b1, 62, 0, 50, 0, LAT);

        // 3: unmatched note-offs (slot 0 only RELEASED) are dropped
        do_event(1'b0, 61, 0, 10, 0, -1);
        chk("drop_1", 32'(drop_count), 32'd1);
        do_event(1'b0, 60, 0, 10, 0, -1);
        chk("drop_2", 32'(drop_count), 32'd2);

        // Retrigger of RELEASED match beats FREE; other channel is not a match
        expect_cmd(0, 1'b1, 60, 0, 90);
        do_event(1'b1, 60, 0, 90, 0, LAT);
        expect_cmd(2, 1'b1, 60, 1, 91);
        do_event(1'b1, 60, 1, 91, 0, LAT);
        chk("steal_none", 32'(steal_count), 32'd0);

        // 4: fill all 32 slots, 33rd steals oldest (slot 0)
        do_reset();
        for (int i = 0; i < NV; i++) begin
            expect_cmd(i, 1'b1, i, 0, i + 10);
            do_event(1'b1, i, 0, i + 10, 0, LAT);
        end
        chk("steal_full", 32'(steal_count), 32'd0);
        expect_cmd(0, 1'b1, 100, 0, 1);
        do_event(1'b1, 100, 0, 1, 0, LAT);
        chk("steal_1", 32'(steal_count), 32'd1);
        expect_cmd(5, 1'b1, 5, 0, 2);
        do_event(1'b1, 5, 0, 2, 0, LAT);
        chk("steal_retrig", 32'(steal_count), 32'd1);

        // 5: RELEASED slot beats oldest HELD
        do_reset();
        for (int i = 0; i < NV; i++) begin
            expect_cmd(i, 1'b1, i, 3, 20);
            do_event(1'b1, i, 3, 20, 0, LAT);
        end
        expect_cmd(5, 1'b0, 5, 3, 7);
        do_event(1'b0, 5, 3, 7, 0, LAT);
        expect_cmd(5, 1'b1, 40, 3, 30);
        do_event(1'b1, 40, 3, 30, 0, LAT);
        chk("steal_rel", 32'(steal_count), 32'd0);
        expect_cmd(0, 1'b1, 41, 3, 31);
        do_event(1'b1, 41, 3, 31, 0, LAT);
        chk("steal_after_rel", 32'(steal_count), 32'd1);

        // 6: sample-engine conflict delays by exactly 10 cycles
        do_reset();
        smp_addr = 8'd0;
        expect_cmd(0, 1'b1, 70, 2, 70);
        do_event(1'b1, 70, 2, 70, 10, LAT + 10);
        smp_addr = 8'd5;
        expect_cmd(1, 1'b1, 71, 2, 71);
        do_event(1'b1, 71, 2, 71, 10, LAT);

        // Reset while in HOLD abandons the event
        smp_addr = 8'd2;
        accept(1'b1, 72, 2, 72, 1);
        repeat (LAT + 4) @(posedge clk32);
        #1;
        chk("hold_no_cmd", 32'(cmd_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk32);
        #1;
        chk_zero("rst_in_hold");
        rst = 1'b0; smp_busy = 1'b0;
        cnt = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk32);
            #1;
            if (cmd_valid) cnt++;
        end
        chk("post_rst_cmd", 32'(cnt), 32'd0);
        expect_cmd(0, 1'b1, 73, 2, 73);
        do_event(1'b1, 73, 2, 73, 0, LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
